// File: rtl/binary_mul_pipe_bi_if.sv
// Handshake bundle for binary_mul_pipe_bi: operand input channel and product output channel.
// The ovf wire exists only when BINARY_MUL_LEGACY_OVF_EN is defined.
interface binary_mul_pipe_bi_if #(
  parameter int WIDTH = 14
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 a_signed;
  logic                 b_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   P;
`ifdef BINARY_MUL_LEGACY_OVF_EN
  logic                 ovf;

  modport master (
    output in_valid, A, B, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, P, ovf
  );
  modport slave (
    input  in_valid, A, B, a_signed, b_signed, out_ready,
    output in_ready, out_valid, P, ovf
  );
`else
  modport master (
    output in_valid, A, B, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, P
  );
  modport slave (
    input  in_valid, A, B, a_signed, b_signed, out_ready,
    output in_ready, out_valid, P
  );
`endif
endinterface

// File: rtl/binary_mul_pipe_bi.sv
// Pipelined WIDTH x WIDTH multiplier with per-operand signedness and valid/ready flow control.
// Optional legacy overflow flag: define BINARY_MUL_LEGACY_OVF_EN.
module binary_mul_pipe_bi #(
  parameter int WIDTH  = 14,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  binary_mul_pipe_bi_if.slave bus
);
  localparam int XW = WIDTH + 1;
  localparam int PW = 2 * WIDTH;

  // One extra bit lets both signed and unsigned operands share a signed multiplier.
  function automatic logic signed [XW-1:0] extend_op(input logic [WIDTH-1:0] v,
                                                     input logic is_signed);
    return {is_signed & v[WIDTH-1], v};
  endfunction

`ifdef BINARY_MUL_LEGACY_OVF_EN
  // Legacy field is 2*WIDTH-1 bits: signed needs the top bits to be a pure sign run.
  function automatic logic legacy_ovf(input logic signed [2*XW-1:0] p,
                                      input logic is_signed);
    if (is_signed)
      return !((&p[2*XW-1:PW-2]) || !(|p[2*XW-1:PW-2]));
    return |p[2*XW-1:PW-1];
  endfunction
`endif

  logic                 adv;
  logic                 in_xfer;

  logic                 vld_p0;
  logic signed [XW-1:0] a_p0;
  logic signed [XW-1:0] b_p0;
  logic [PW-1:0]        prod_next;

  logic                 vld_p  [STAGES];
  logic [PW-1:0]        prod_p [STAGES];

`ifdef BINARY_MUL_LEGACY_OVF_EN
  logic                   sgn_p0;
  logic signed [2*XW-1:0] full_prod;
  logic                   ovf_next;
  logic                   ovf_p [STAGES];

  assign full_prod = a_p0 * b_p0;
  assign prod_next = full_prod[PW-1:0];
  assign ovf_next  = legacy_ovf(full_prod, sgn_p0);
  assign bus.ovf   = ovf_p[STAGES-1];
`else
  assign prod_next = PW'(a_p0 * b_p0);
`endif

  assign adv         = en & (~vld_p[STAGES-1] | bus.out_ready);
  assign bus.in_ready = adv & rst_n;
  assign in_xfer     = bus.in_valid & bus.in_ready;

  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.P         = prod_p[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
`ifdef BINARY_MUL_LEGACY_OVF_EN
      sgn_p0 <= 1'b0;
`endif
      for (int i = 0; i < STAGES; i++) begin
        vld_p[i]  <= 1'b0;
        prod_p[i] <= '0;
`ifdef BINARY_MUL_LEGACY_OVF_EN
        ovf_p[i]  <= 1'b0;
`endif
      end
    end else if (adv) begin
      // p0: capture extended operands (bubble when no input transfer)
      vld_p0 <= in_xfer;
      a_p0   <= extend_op(bus.A, bus.a_signed);
      b_p0   <= extend_op(bus.B, bus.b_signed);
`ifdef BINARY_MUL_LEGACY_OVF_EN
      sgn_p0 <= bus.a_signed | bus.b_signed;
`endif
      // p1: truncated product enters the product chain
      vld_p[0]  <= vld_p0;
      prod_p[0] <= prod_next;
`ifdef BINARY_MUL_LEGACY_OVF_EN
      ovf_p[0]  <= ovf_next;
`endif
      // p2..: delay-only stages up to the output register
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i]  <= vld_p[i-1];
        prod_p[i] <= prod_p[i-1];
`ifdef BINARY_MUL_LEGACY_OVF_EN
        ovf_p[i]  <= ovf_p[i-1];
`endif
      end
    end
  end

endmodule
